// File: rtl/game_pkg.sv
// Shared definitions for the flappy-bird controller and its datapath: state codes,
// scoring geometry and the BCD score increment.
package game_pkg;

    typedef enum logic [3:0] {
        S_DRAW_BIRD      = 4'd0,
        S_DRAW_WALL_TOP  = 4'd1,
        S_DRAW_WALL_BOT  = 4'd2,
        S_WAIT           = 4'd3,
        S_ERASE_BIRD     = 4'd4,
        S_ERASE_WALL_TOP = 4'd5,
        S_ERASE_WALL_BOT = 4'd6,
        S_UPDATE         = 4'd7,
        S_CHECK          = 4'd8,
        S_IDLE           = 4'd9,
        S_GAME_OVER      = 4'd10
    } state_t;

    localparam logic [7:0] BIRD_LEFT_X     = 8'd8;
    localparam logic [7:0] SCORE_X_DEFAULT = BIRD_LEFT_X;
    localparam int         BCD_W           = 4;

    function automatic logic is_erase_state(input state_t s);
        return (s == S_ERASE_BIRD) || (s == S_ERASE_WALL_TOP) || (s == S_ERASE_WALL_BOT);
    endfunction

    function automatic logic is_plot_state(input state_t s);
        return (s == S_DRAW_BIRD) || (s == S_DRAW_WALL_TOP) || (s == S_DRAW_WALL_BOT)
            || is_erase_state(s);
    endfunction

    // Two-digit BCD increment; 99 wraps to 00.
    function automatic logic [2*BCD_W-1:0] bcd_inc(input logic [2*BCD_W-1:0] v);
        logic [BCD_W-1:0] ones;
        logic [BCD_W-1:0] tens;
        ones = v[BCD_W-1:0];
        tens = v[2*BCD_W-1:BCD_W];
        if (ones == BCD_W'(9)) begin
            ones = '0;
            tens = (tens == BCD_W'(9)) ? '0 : tens + BCD_W'(1);
        end else begin
            ones = ones + BCD_W'(1);
        end
        return {tens, ones};
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Frame pacing counter: counts clk cycles while a game is running and pulses tick
// on the last cycle of each frame, wrapping back to zero.
module frame_timer #(
    parameter int FRAME_CYCLES = 833333
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_CYCLES - 1);

    logic [CW-1:0] frame_count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            frame_count <= '0;
        end else if (frame_count == LAST) begin
            frame_count <= '0;
        end else begin
            frame_count <= frame_count + CW'(1);
        end
    end

    assign tick = (frame_count == LAST);

endmodule

// File: rtl/game_control.sv
// Game sequencing FSM: draw/erase/update loop, flap request capture, BCD score.
//   state            | meaning
//   S_DRAW_BIRD      | plot bird in foreground colour
//   S_DRAW_WALL_TOP  | plot upper wall segment
//   S_DRAW_WALL_BOT  | plot lower wall segment
//   S_WAIT           | idle until the frame timer expires
//   S_ERASE_BIRD     | repaint bird in background colour
//   S_ERASE_WALL_TOP | repaint upper wall in background colour
//   S_ERASE_WALL_BOT | repaint lower wall in background colour
//   S_UPDATE         | one-cycle frame_tick, flap and scoring
//   S_CHECK          | one cycle for datapath to settle, then collision test
//   S_IDLE           | waiting for start
//   S_GAME_OVER      | game frozen until start
module game_control
    import game_pkg::*;
#(
    parameter int          FRAME_CYCLES = 833333,
    parameter logic [7:0]  SCORE_X      = SCORE_X_DEFAULT,
    parameter logic [15:0] DRAW_TIMEOUT = 16'hFFFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       flap_req,
    input  logic       finished_draw,
    input  logic       collision,
    input  logic [7:0] wall_x,
    output logic [3:0] cur_state,
    output logic       erase,
    output logic       plot,
    output logic       frame_tick,
    output logic       flap,
    output logic [7:0] score_out,
    output logic       game_over
);

    localparam logic [15:0] TIMER_LOAD = DRAW_TIMEOUT - 16'd1;

    state_t      state;
    state_t      state_n;
    logic [15:0] draw_timer;
    logic [2:0]  flap_sync;
    logic        flap_latch;
    logic        flap_edge;
    logic        draw_done;
    logic        frame_done;
    logic        timer_clear;

    assign cur_state   = state;
    assign flap_edge   = flap_sync[1] & ~flap_sync[2];
    assign timer_clear = (state == S_IDLE) || (state == S_GAME_OVER);

    // The timer is reloaded on every state change, so its load value marks the
    // first cycle in a state, where a stale finished_draw pulse is ignored.
    assign draw_done = (finished_draw && (draw_timer != TIMER_LOAD)) || (draw_timer == 16'd0);

    frame_timer #(
        .FRAME_CYCLES(FRAME_CYCLES)
    ) u_frame_timer (
        .clk  (clk),
        .reset(reset),
        .clear(timer_clear),
        .tick (frame_done)
    );

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:           if (start)      state_n = S_DRAW_BIRD;
            S_DRAW_BIRD:      if (draw_done)  state_n = S_DRAW_WALL_TOP;
            S_DRAW_WALL_TOP:  if (draw_done)  state_n = S_DRAW_WALL_BOT;
            S_DRAW_WALL_BOT:  if (draw_done)  state_n = S_WAIT;
            S_WAIT:           if (frame_done) state_n = S_ERASE_BIRD;
            S_ERASE_BIRD:     if (draw_done)  state_n = S_ERASE_WALL_TOP;
            S_ERASE_WALL_TOP: if (draw_done)  state_n = S_ERASE_WALL_BOT;
            S_ERASE_WALL_BOT: if (draw_done)  state_n = S_UPDATE;
            S_UPDATE:                         state_n = S_CHECK;
            S_CHECK:          state_n = collision ? S_GAME_OVER : S_DRAW_BIRD;
            S_GAME_OVER:      if (start)      state_n = S_IDLE;
            default:                          state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            draw_timer <= TIMER_LOAD;
            flap_sync  <= '0;
            flap_latch <= 1'b0;
            score_out  <= 8'h00;
            erase      <= 1'b0;
            plot       <= 1'b0;
            frame_tick <= 1'b0;
            flap       <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            state     <= state_n;
            flap_sync <= {flap_sync[1:0], flap_req};

            if (state_n != state) begin
                draw_timer <= TIMER_LOAD;
            end else if (draw_timer != 16'd0) begin
                draw_timer <= draw_timer - 16'd1;
            end

            // An edge arriving during S_UPDATE survives the clear and counts next frame.
            if (timer_clear) begin
                flap_latch <= 1'b0;
            end else if (state == S_UPDATE) begin
                flap_latch <= flap_edge;
            end else begin
                flap_latch <= flap_latch | flap_edge;
            end

            if ((state == S_IDLE) && start) begin
                score_out <= 8'h00;
            end else if ((state == S_UPDATE) && (wall_x == SCORE_X)) begin
                score_out <= bcd_inc(score_out);
            end

            erase      <= is_erase_state(state_n);
            plot       <= is_plot_state(state_n);
            frame_tick <= (state_n == S_UPDATE);
            flap       <= (state_n == S_UPDATE) && (flap_latch || flap_edge);
            game_over  <= (state_n == S_GAME_OVER);
        end
    end

endmodule

// File: tb/tb_game_control.sv
// Bench for game_control: directed scenarios plus randomized play, checked every cycle
// against a behavioural model of the game rules.
module tb_game_control;

    localparam int FC    = 20;
    localparam int TO    = 50;
    localparam int SCORE = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       flap_req = 1'b0;
    logic       finished_draw = 1'b0;
    logic       collision = 1'b0;
    logic [7:0] wall_x = 8'd0;
    logic [3:0] cur_state;
    logic       erase, plot, frame_tick, flap, game_over;
    logic [7:0] score_out;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    // Datapath emulation controls
    int fd_mode    = 0;   // 0: pulse at fd_delay, 1: held high, 2: never
    int fd_delay   = 3;
    bit coll_en    = 1'b0;
    bit coll_force = 1'b0;

    // Behavioural model: state code, cycles already spent in it, cycles since game start,
    // decimal score, pending flap, flap output for the current update cycle, flap_req samples.
    int       m_state = 9;
    int       m_cyc   = 0;
    int       m_frame = 0;
    int       m_score = 0;
    bit       m_pend  = 1'b0;
    bit       m_flap  = 1'b0;
    bit [2:0] m_h     = 3'b000;

    game_control #(
        .FRAME_CYCLES(FC),
        .SCORE_X     (8'd8),
        .DRAW_TIMEOUT(16'd50)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .flap_req     (flap_req),
        .finished_draw(finished_draw),
        .collision    (collision),
        .wall_x       (wall_x),
        .cur_state    (cur_state),
        .erase        (erase),
        .plot         (plot),
        .frame_tick   (frame_tick),
        .flap         (flap),
        .score_out    (score_out),
        .game_over    (game_over)
    );

    always #5 clk = ~clk;

    function automatic bit m_plot(input int s);
        return (s >= 0 && s <= 2) || (s >= 4 && s <= 6);
    endfunction

    function automatic bit m_erase(input int s);
        return (s >= 4 && s <= 6);
    endfunction

    function automatic logic [7:0] m_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic timeout_fail(input string name, input int budget);
        n_checks++;
        $display("FAIL %s: not reached within %0d cycles at %0t", name, budget, $time);
    endtask

    always @(posedge clk) begin : model
        int nxt;
        bit e;
        e = m_h[1] & ~m_h[2];   // rise seen after two synchroniser stages
        if (reset) begin
            m_state = 9; m_cyc = 0; m_frame = 0; m_score = 0;
            m_pend = 1'b0; m_flap = 1'b0; m_h = 3'b000;
        end else begin
            nxt = m_state;
            case (m_state)
                9: if (start) begin nxt = 0; m_score = 0; end
                0, 1, 2, 4, 5, 6:
                    if ((m_cyc > 0 && finished_draw) || m_cyc == TO - 1)
                        nxt = (m_state == 2) ? 3 : (m_state == 6) ? 7 : m_state + 1;
                3: if (m_frame % FC == FC - 1) nxt = 4;
                7: begin nxt = 8; if (wall_x == 8'(SCORE)) m_score = (m_score + 1) % 100; end
                8: nxt = collision ? 10 : 0;
                10: if (start) nxt = 9;
                default: nxt = 9;
            endcase
            m_flap = (nxt == 7) && (m_pend || e);
            if (m_state == 9 || m_state == 10) m_pend = 1'b0;
            else if (m_state == 7) m_pend = e;
            else m_pend = m_pend | e;
            m_frame = (m_state == 9 || m_state == 10) ? 0 : m_frame + 1;
            m_cyc   = (nxt == m_state) ? m_cyc + 1 : 0;
            m_state = nxt;
            m_h     = {m_h[1:0], flap_req};
        end
    end

    always @(posedge clk) begin : datapath_emu
        #2;
        case (fd_mode)
            0:       finished_draw = m_plot(m_state) && (m_cyc == fd_delay);
            1:       finished_draw = 1'b1;
            default: finished_draw = 1'b0;
        endcase
        collision = coll_force || (coll_en && ($urandom_range(0, 7) == 0));
    end

    always @(negedge clk) begin : compare
        if (cmp_en) begin
            chk("cur_state",  32'(cur_state),  32'(m_state));
            chk("plot",       32'(plot),       32'(m_plot(m_state)));
            chk("erase",      32'(erase),      32'(m_erase(m_state)));
            chk("game_over",  32'(game_over),  32'(m_state == 10));
            chk("frame_tick", 32'(frame_tick), 32'(m_state == 7));
            chk("flap",       32'(flap),       32'(m_state == 7 && m_flap));
            chk("score_out",  32'(score_out),  32'(m_bcd(m_score)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_model(input int s, input int budget);
        int n = 0;
        while (m_state != s && n < budget) begin tick(); n++; end
        if (m_state != s) timeout_fail($sformatf("wait_state_%0d", s), budget);
    endtask

    task automatic wait_model_cyc(input int s, input int c, input int budget);
        int n = 0;
        while (!(m_state == s && m_cyc == c) && n < budget) begin tick(); n++; end
        if (!(m_state == s && m_cyc == c)) timeout_fail($sformatf("wait_state_%0d_cyc_%0d", s, c), budget);
    endtask

    task automatic wait_frames(input int n);
        for (int i = 0; i < n; i++) begin
            wait_model(7, 400);
            wait_model(8, 400);
        end
    endtask

    task automatic measure_state(input int s, output int len);
        int n = 0;
        len = 0;
        while (32'(cur_state) != s && n < 400) begin tick(); n++; end
        while (32'(cur_state) == s && len < 400) begin len++; tick(); end
    endtask

    // Counts flap pulses (and flap pulses not on frame_tick) until the next check cycle.
    task automatic count_flaps(output int cnt, output int bad);
        int n = 0;
        cnt = 0;
        bad = 0;
        do begin
            tick();
            n++;
            if (flap === 1'b1) cnt++;
            if (flap === 1'b1 && frame_tick !== 1'b1) bad++;
        end while (m_state != 8 && n < 500);
        if (m_state != 8) timeout_fail("flap_window", 500);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin : stimulus
        int len, cnt, bad, r;

        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        cmp_en = 1'b1;
        chk("rst_state", 32'(cur_state), 32'(9));
        chk("rst_score", 32'(score_out), 32'(0));
        chk("rst_plot",  32'(plot),      32'(0));
        chk("rst_over",  32'(game_over), 32'(0));

        // Draw sequence with finished_draw three cycles into each state
        fd_mode = 0; fd_delay = 3;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 13; i++) begin
            chk("t1_seq",  32'(cur_state), 32'((i < 12) ? i / 4 : 3));
            chk("t1_plot", 32'(plot),      32'(i < 12));
            tick();
        end

        // finished_draw held high: first-cycle guard gives two cycles
        fd_mode = 1;
        measure_state(1, len);
        chk("t2_guard_len", 32'(len), 32'(2));

        // Two rises in one frame give one flap; a rise seen in update waits a frame
        fd_mode = 0; fd_delay = 3;
        wait_model(3, 400);
        flap_req = 1'b1; tick(); flap_req = 1'b0; tick(); flap_req = 1'b1; tick(); flap_req = 1'b0;
        count_flaps(cnt, bad);
        chk("t3_one_flap", 32'(cnt), 32'(1));
        chk("t3_aligned",  32'(bad), 32'(0));
        wait_model_cyc(6, 2, 400);
        flap_req = 1'b1;
        count_flaps(cnt, bad);
        chk("t3_edge_in_update_now", 32'(cnt), 32'(0));
        count_flaps(cnt, bad);
        chk("t3_edge_in_update_next", 32'(cnt), 32'(1));
        flap_req = 1'b0;

        // Scoring: carry into tens, wrap at 99, then game over freezes the score
        reset = 1'b1; tick(); reset = 1'b0;
        fd_mode = 0; fd_delay = 1; wall_x = 8'd8;
        start = 1'b1; tick(); start = 1'b0;
        wait_frames(9);
        chk("t4_score_09", 32'(score_out), 32'(8'h09));
        wait_frames(1);
        chk("t4_score_10", 32'(score_out), 32'(8'h10));
        wait_frames(89);
        chk("t4_score_99", 32'(score_out), 32'(8'h99));
        wait_frames(1);
        chk("t4_score_wrap", 32'(score_out), 32'(8'h00));
        wait_frames(1);
        chk("t4_score_01", 32'(score_out), 32'(8'h01));
        wall_x = 8'd0; coll_force = 1'b1;
        wait_model(10, 400);
        chk("t5_state", 32'(cur_state), 32'(10));
        chk("t5_over",  32'(game_over), 32'(1));
        chk("t5_plot",  32'(plot),      32'(0));
        repeat (3) tick();
        chk("t5_score_held", 32'(score_out), 32'(8'h01));
        coll_force = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        chk("t5_to_idle", 32'(cur_state), 32'(9));

        // Draw timeout, then reset in the middle of a draw
        fd_mode = 2;
        start = 1'b1; tick(); start = 1'b0;
        measure_state(0, len);
        chk("t6_timeout_len", 32'(len), 32'(TO));
        repeat (3) tick();
        reset = 1'b1; tick();
        chk("t6_rst_state", 32'(cur_state),  32'(9));
        chk("t6_rst_plot",  32'(plot),       32'(0));
        chk("t6_rst_erase", 32'(erase),      32'(0));
        chk("t6_rst_tick",  32'(frame_tick), 32'(0));
        chk("t6_rst_flap",  32'(flap),       32'(0));
        chk("t6_rst_over",  32'(game_over),  32'(0));
        chk("t6_rst_score", 32'(score_out),  32'(0));
        reset = 1'b0;

        // Randomized play
        for (int c = 0; c < 3000; c++) begin
            if (c % 300 == 0) begin
                r = int'($urandom_range(0, 9));
                fd_mode  = (r < 7) ? 0 : ((r < 9) ? 1 : 2);
                fd_delay = int'($urandom_range(0, 5));
                coll_en  = ($urandom_range(0, 2) == 0);
            end
            if ($urandom_range(0, 3) == 0) flap_req = ~flap_req;
            wall_x = ($urandom_range(0, 1) == 1) ? 8'd8 : 8'($urandom_range(0, 255));
            start  = ($urandom_range(0, 11) == 0);
            reset  = ($urandom_range(0, 499) == 0);
            tick();
        end
        reset = 1'b0; start = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
